// File: rtl/regfile_writeback.sv
// Register file write-port producer.
// Merges single-cycle ALU results and buffered multi-cycle load results onto
// the single register file write port, and tracks which registers still have
// a write in flight so issue logic can stall on RAW/WAW hazards.
//
// Handshake: a load result transfers on a clock edge where mem_valid and
// mem_ready are both high; mem_ready depends only on registered occupancy, so
// it never combinationally follows mem_valid. ALU results have no ready and
// are taken on every edge where alu_valid is high.
module regfile_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        issue_valid,
   input  logic [ADDR_W-1:0]           issue_rd,
   input  logic                        alu_valid,
   input  logic [ADDR_W-1:0]           alu_rd,
   input  logic [DATA_W-1:0]           alu_data,
   input  logic                        mem_valid,
   output logic                        mem_ready,
   input  logic [ADDR_W-1:0]           mem_rd,
   input  logic [DATA_W-1:0]           mem_data,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [2**ADDR_W-1:0]        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 2**ADDR_W;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR1_C  = PTR_W'(1);

   // Load result buffer storage (data path only, no reset needed).
   logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0]   busy_q, busy_d;

   logic              push, pop;
   logic              sel_valid;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   assign mem_ready  = (count_q < DEPTH_C);
   assign push       = mem_valid && mem_ready;
   // The head is only eligible when the ALU is silent; a freshly pushed entry
   // is not visible until count_q reflects it, so there is no bypass.
   assign pop        = !alu_valid && (count_q != '0);

   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;
   assign busy       = busy_q;
   assign fifo_count = count_q;
   assign idle       = (count_q == '0) && !rf_we_q && (busy_q == '0);

   // Pick this cycle's write winner: ALU first, else the buffered load head.
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end else if (pop) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd_q[rd_ptr_q];
         sel_data  = fifo_data_q[rd_ptr_q];
      end
   end

   // Next-state for pointers, occupancy and the registered write port.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR1_C;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR1_C;
      case ({push, pop})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
      // A winner targeting x0 is consumed but never reaches the register file.
      if (sel_valid && (sel_rd != '0)) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = sel_rd;
         rf_wdata_d = sel_data;
      end
   end

   // Scoreboard update: clear on commit, then set on issue so a same-edge
   // set of the same register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
      if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   // Load buffer write; entries are only reachable through the pointers.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         fifo_rd_q[wr_ptr_q]   <= mem_rd;
         fifo_data_q[wr_ptr_q] <= mem_data;
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback. Expected register file writes are
// queued in appearance order by the stimulus; a negedge monitor pops and
// compares whenever rf_we is high. State outputs are checked #1 after edges.
module tb_regfile_writeback;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int ND = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          alu_valid;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_data;
   logic          mem_valid;
   logic          mem_ready;
   logic [AW-1:0] mem_rd;
   logic [DW-1:0] mem_data;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0]   busy;
   logic [2:0]    fifo_count;
   logic          idle;

   int checks = 0;
   int errors = 0;

   logic [AW+DW-1:0] exp_q[$];

   regfile_writeback #(.FIFO_DEPTH(ND), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_rd(mem_rd), .mem_data(mem_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .fifo_count(fifo_count), .idle(idle)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input int rd, input int data);
      exp_q.push_back({AW'(rd), DW'(data)});
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; issue_rd = '0;
      alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
      mem_valid   = 1'b0; mem_rd   = '0; mem_data = '0;
   endtask

   // Scoreboard monitor: every register file write must match the queue head.
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         checks++;
         if (rf_waddr == '0) begin
            errors++;
            $display("FAIL wr_x0 actual=%0h required=nonzero", rf_waddr);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected actual=%0h:%0h required=none", rf_waddr, rf_wdata);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== e) begin
               errors++;
               $display("FAIL wr_data actual=%0h:%0h required=%0h:%0h",
                        rf_waddr, rf_wdata, e[AW+DW-1:DW], e[DW-1:0]);
            end
         end
      end
   end

   // Protocol guard: upstream must never issue to a register still pending.
   always @(posedge clk) begin
      if (!reset && issue_valid && busy[issue_rd]) begin
         errors++;
         $display("FAIL issue_busy actual=%0d required=notbusy", issue_rd);
      end
   end

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_idle", idle, 1);
      chk("rst_ready", mem_ready, 1);

      // ALU passthrough with scoreboard set/clear.
      exp_push(5, 'hDEADBEEF);
      issue_valid = 1'b1; issue_rd = 5;
      tick();
      chk("t1_busy_set", busy, 32'h20);
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5; alu_data = 'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      chk("t1_we", rf_we, 1);
      chk("t1_busy_hold", busy, 32'h20);
      tick();
      chk("t1_busy_clr", busy, 0);
      chk("t1_idle", idle, 1);

      // Load buffering, no ALU traffic.
      exp_push(1, 'h11); exp_push(2, 'h22); exp_push(3, 'h33);
      mem_valid = 1'b1; mem_rd = 1; mem_data = 'h11;
      tick();
      chk("t2_cnt_a", fifo_count, 1);
      chk("t2_no_bypass", rf_we, 0);
      mem_rd = 2; mem_data = 'h22;
      tick();
      chk("t2_cnt_b", fifo_count, 1);
      chk("t2_lat2_we", rf_we, 1);
      chk("t2_lat2_addr", rf_waddr, 1);
      mem_rd = 3; mem_data = 'h33;
      tick();
      chk("t2_cnt_c", fifo_count, 1);
      mem_valid = 1'b0;
      tick();
      chk("t2_cnt_d", fifo_count, 0);
      chk("t2_last_addr", rf_waddr, 3);
      tick();
      chk("t2_idle", idle, 1);

      // Priority and starvation: ALU holds off the FIFO until it fills.
      for (int i = 0; i < 5; i++) exp_push(10 + i, 'hA0 + i);
      for (int i = 0; i < 4; i++) exp_push(20 + i, 'h100 + i);
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = AW'(10 + i); alu_data = DW'('hA0 + i);
         mem_valid = 1'b1; mem_rd = AW'(20 + i); mem_data = DW'('h100 + i);
         tick();
         chk("t3_fill_cnt", fifo_count, 64'(i + 1));
      end
      chk("t3_full_ready", mem_ready, 0);
      alu_rd = 14; alu_data = 'hA4;
      mem_rd = 24; mem_data = 'h1FF;
      tick();
      chk("t3_refused_cnt", fifo_count, 4);
      chk("t3_refused_ready", mem_ready, 0);
      alu_valid = 1'b0; mem_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_drain_cnt", fifo_count, 64'(3 - i));
         chk("t3_drain_we", rf_we, 1);
         chk("t3_drain_addr", rf_waddr, 64'(20 + i));
         chk("t3_drain_ready", mem_ready, 1);
      end
      tick();

      // Full with simultaneous offer, then push+pop with pointer wrap.
      for (int i = 0; i < 4; i++) exp_push(12, 'h300 + i);
      for (int i = 0; i < 4; i++) exp_push(16 + i, 'h200 + i);
      exp_push(26, 'h260);
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 12; alu_data = DW'('h300 + i);
         mem_valid = 1'b1; mem_rd = AW'(16 + i); mem_data = DW'('h200 + i);
         tick();
      end
      chk("t4_full_cnt", fifo_count, 4);
      alu_valid = 1'b0;
      mem_rd = 25; mem_data = 'h250;
      tick();
      chk("t4_refuse_pop_cnt", fifo_count, 3);
      mem_rd = 26; mem_data = 'h260;
      tick();
      chk("t4_pushpop_cnt", fifo_count, 3);
      mem_valid = 1'b0;
      tick(); chk("t4_drain2", fifo_count, 2);
      tick(); chk("t4_drain1", fifo_count, 1);
      tick(); chk("t4_drain0", fifo_count, 0);
      chk("t4_wrap_addr", rf_waddr, 26);
      tick();

      // x0 results are consumed without a write.
      alu_valid = 1'b1; alu_rd = 0; alu_data = 'hBAD;
      tick();
      alu_valid = 1'b0;
      chk("t5_alu_x0", rf_we, 0);
      mem_valid = 1'b1; mem_rd = 0; mem_data = 'hBAD0;
      tick();
      mem_valid = 1'b0;
      chk("t5_load_x0_cnt", fifo_count, 1);
      tick();
      chk("t5_load_x0_pop", fifo_count, 0);
      chk("t5_load_x0_we", rf_we, 0);

      // Issue of r7 on the edge its (unscoreboarded) write commits: set wins.
      exp_push(7, 'h77);
      alu_valid = 1'b1; alu_rd = 7; alu_data = 'h77;
      tick();
      alu_valid = 1'b0;
      issue_valid = 1'b1; issue_rd = 7;
      tick();
      issue_valid = 1'b0;
      chk("t5_set_wins", busy, 32'h80);
      chk("t5_not_idle", idle, 0);
      exp_push(7, 'h78);
      alu_valid = 1'b1; alu_rd = 7; alu_data = 'h78;
      tick();
      alu_valid = 1'b0;
      tick();
      chk("t5_busy_clr", busy, 0);

      // Reset with buffered loads and pending scoreboard bits.
      for (int i = 0; i < 3; i++) exp_push(4, 'h44 + i);
      issue_valid = 1'b1; issue_rd = 3;
      alu_valid = 1'b1; alu_rd = 4; alu_data = 'h44;
      mem_valid = 1'b1; mem_rd = 3; mem_data = 'hE1;
      tick();
      issue_rd = 9; alu_data = 'h45; mem_rd = 9; mem_data = 'hE2;
      tick();
      issue_valid = 1'b0; alu_data = 'h46; mem_rd = 30; mem_data = 'hE3;
      tick();
      chk("t6_pre_cnt", fifo_count, 3);
      chk("t6_pre_busy", busy, 32'h208);
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_we", rf_we, 0);
      chk("t6_busy", busy, 0);
      chk("t6_cnt", fifo_count, 0);
      chk("t6_idle", idle, 1);
      for (int i = 0; i < 6; i++) tick();
      chk("t6_post_cnt", fifo_count, 0);
      chk("t6_post_idle", idle, 1);

      chk("exp_q_empty", 64'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Producer side of the register file write port.
- Merges single-cycle ALU results and multi-cycle load results into the register file's single write port (we/write_addr/write_data).
- Buffers load results in a small FIFO.
- Keeps a per-register pending-write scoreboard, which issue logic uses for RAW/WAW hazard stalls.

Parameters:
- FIFO_DEPTH, 4, number of buffered load results (power of 2, >=2)
- DATA_W, 32, result data width
- ADDR_W, 5, register index width (32 registers, x0 hardwired zero)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- issue_valid  input  1  an instruction with destination issue_rd is issued this cycle
- issue_rd  input  ADDR_W  destination register of the issued instruction
- alu_valid  input  1  ALU result present; always accepted, no backpressure
- alu_rd  input  ADDR_W  ALU result destination
- alu_data  input  DATA_W  ALU result value
- mem_valid  input  1  load result offered
- mem_ready  output  1  FIFO can accept a load result (count < FIFO_DEPTH)
- mem_rd  input  ADDR_W  load destination
- mem_data  input  DATA_W  load value
- rf_we  output  1  register file write enable
- rf_waddr  output  ADDR_W  register file write address
- rf_wdata  output  DATA_W  register file write data
- busy  output  2**ADDR_W  scoreboard; bit i=1 means a write to register i is pending
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- idle  output  1  fifo_count==0 && !rf_we && busy==0

Behaviour:
- Reset: synchronous, highest priority.
  - Sets rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, fifo_count=0; FIFO pointers go to 0.
  - Reset mid-operation discards all buffered load results without writing them.
- Outputs rf_we/rf_waddr/rf_wdata are registered, so there is one-cycle latency from selection to write.
- Write select each cycle (winner is registered onto rf_* next edge):
  - alu_valid=1: the ALU result wins; the FIFO does not pop.
  - Otherwise, if fifo_count>0: the FIFO head pops and wins.
  - Otherwise: rf_we<=0. rf_waddr/rf_wdata hold their previous values.
- x0 handling:
  - A winner with rd==0 is consumed (FIFO pops if it was the head) but drives rf_we<=0.
  - rf_we is never 1 with rf_waddr==0.
- FIFO push: on mem_valid && mem_ready.
  - mem_ready is combinational: (fifo_count < FIFO_DEPTH).
  - When full, push is refused even if a pop happens the same cycle.
- Simultaneous push and pop: count is unchanged and pointers both advance; wrap-around is modulo FIFO_DEPTH.
- Push into an empty FIFO: the entry is eligible to pop no earlier than the next cycle (no same-cycle bypass). Minimum load-to-rf_we latency is 2 cycles.
- ALU starvation of the FIFO is permitted; the FIFO drains in FIFO order once alu_valid drops.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the next edge.
  - Clear: busy[rf_waddr] clears at the edge after rf_we=1, i.e. the same edge the register file commits.
  - Same register set and cleared on the same edge: set wins, and busy stays 1.
  - busy[0] is always 0.
- Protocol rule: issue_valid with busy[issue_rd]==1 is illegal. Upstream stalls in that case; the bench asserts it never happens.
- Results for a register whose busy bit is 0 are still written; the scoreboard bit stays 0.
- idle is combinational from the registered state.

Test Plan:
- ALU passthrough: issue rd=5, then alu_valid rd=5 data=0xDEADBEEF at cycle N -> rf_we=1, waddr=5, wdata=0xDEADBEEF at N+1; busy[5] 1->0 at N+2.
- Load buffering: 3 loads (rd=1,2,3 data=0x11,0x22,0x33) on consecutive cycles with no ALU traffic -> writes 1,2,3 in order starting 2 cycles after the first push; fifo_count peaks at 1.
- Priority/starvation: fill FIFO to 4 with alu_valid held high -> mem_ready=0, fifo_count=4, only ALU writes appear. Drop alu_valid -> 4 load writes on 4 consecutive cycles, and mem_ready rises the cycle after the first pop.
- Full + simultaneous push/pop: count=4, alu_valid=0, mem_valid=1 -> push refused, one pop, count=3. Next cycle push+pop -> count stays 3; pointer wrap verified by data order.
- x0 and busy collision:
  - ALU rd=0 -> rf_we stays 0.
  - Load rd=0 -> FIFO pops with no write.
  - issue rd=7 on the same edge as the write of rd=7 completes -> busy[7] remains 1.
- Reset mid-operation: FIFO count=3, busy bits set, assert reset for 1 cycle -> rf_we=0, busy=0, fifo_count=0, idle=1; no buffered data is ever written afterwards.
